// File: rtl/align_sched_pkg.sv
// Shared types and widths for the partial-product alignment scheduler.
// The ALIGN_SCHED_ZERO_SKIP_EN build uses SHIFT_LIMIT and the skip flag.
package align_sched_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, ALIGN, DONE} state_t;

  localparam int PP_W  = 4;
  localparam int EXP_W = 6;
  localparam int ALP_W = 15;

  // The aligner returns zero once the exponent gap reaches this value
  localparam logic [EXP_W-1:0] SHIFT_LIMIT = 6'd12;

  typedef struct packed {
    logic [PP_W-1:0]  pp;
    logic [EXP_W-1:0] exp;
    logic             skip;
  } entry_t;

endpackage

// File: rtl/align_sched_buf.sv
// NUM_PP-entry pp/exp register file: one write port, async read at raddr.
// Latency: write visible next cycle. Backpressure: none. ALIGN_SCHED_ZERO_SKIP_EN adds the next-unskipped finder.
module align_sched_buf
  import align_sched_pkg::*;
#(
  parameter int NUM_PP = 4,
  parameter int IDX_W  = $clog2(NUM_PP)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [PP_W-1:0]  wr_pp,
  input  logic [EXP_W-1:0] wr_exp,
  input  logic [IDX_W-1:0] raddr,
`ifdef ALIGN_SCHED_ZERO_SKIP_EN
  input  logic [EXP_W-1:0] fmax,
  input  logic [IDX_W:0]   fstart,
  output logic [IDX_W-1:0] nxt_idx,
  output logic             nxt_found,
`endif
  output logic [PP_W-1:0]  rd_pp,
  output logic [EXP_W-1:0] rd_exp
);

  logic [PP_W-1:0]  pp_q  [NUM_PP];
  logic [EXP_W-1:0] exp_q [NUM_PP];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PP; i++) begin
        pp_q[i]  <= '0;
        exp_q[i] <= '0;
      end
    end else if (we) begin
      pp_q[waddr]  <= wr_pp;
      exp_q[waddr] <= wr_exp;
    end
  end

  assign rd_pp  = pp_q[raddr];
  assign rd_exp = exp_q[raddr];

`ifdef ALIGN_SCHED_ZERO_SKIP_EN
  logic [NUM_PP-1:0] skip_q;
  logic [NUM_PP-1:0] eff_skip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  skip_q <= '0;
    else if (we) skip_q[waddr] <= (wr_pp[2:0] == 3'b000);
  end

  // The beat being written this cycle is bypassed so the last load beat can pick the first ALIGN index
  always_comb begin
    eff_skip = '0;
    for (int i = 0; i < NUM_PP; i++) begin
      if (we && waddr == IDX_W'(i))
        eff_skip[i] = (wr_pp[2:0] == 3'b000) || ((fmax - wr_exp) >= SHIFT_LIMIT);
      else
        eff_skip[i] = skip_q[i] || ((fmax - exp_q[i]) >= SHIFT_LIMIT);
    end
  end

  always_comb begin
    nxt_idx   = '0;
    nxt_found = 1'b0;
    for (int i = NUM_PP - 1; i >= 0; i--) begin
      if (!eff_skip[i] && ((IDX_W+1)'(i) >= fstart)) begin
        nxt_idx   = IDX_W'(i);
        nxt_found = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/align_sched.sv
// Time-shares one aligner over NUM_PP buffered pp/exp beats and sums the signed aligned results.
// Latency: NUM_PP+1 cycles last beat to o_valid (non-skipped count + 1 with ALIGN_SCHED_ZERO_SKIP_EN).
// Backpressure: o_pp_ready low during ALIGN/DONE; result held in DONE until i_ready.
module align_sched
  import align_sched_pkg::*;
#(
  parameter int NUM_PP = 4,
  parameter int IDX_W  = $clog2(NUM_PP),
  parameter int ACC_W  = ALP_W + IDX_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pp_valid,
  output logic             o_pp_ready,
  input  logic [PP_W-1:0]  i_denorm_pp,
  input  logic [EXP_W-1:0] i_exp,
  output logic [PP_W-1:0]  o_al_pp,
  output logic [EXP_W-1:0] o_al_exp,
  output logic [EXP_W-1:0] o_al_max_exp,
  input  logic [ALP_W-1:0] i_al_result,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [ACC_W-1:0] o_sum,
  output logic [EXP_W-1:0] o_max_exp,
  output logic             o_busy
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PP - 1);

  state_t           state, nstate;
  logic [IDX_W-1:0] cnt, idx, first_idx, step_idx;
  logic [EXP_W-1:0] max_q, new_max;
  logic [ACC_W-1:0] acc, sum_nxt;
  logic [PP_W-1:0]  rd_pp, hold_pp;
  logic [EXP_W-1:0] rd_exp, hold_exp, hold_max;
  logic             accept, last_beat, last_align, skip_all;

  assign accept    = i_pp_valid && o_pp_ready;
  assign last_beat = accept && (state == LOAD) && (cnt == LAST);
  assign new_max   = (state == IDLE || i_exp > max_q) ? i_exp : max_q;
  assign sum_nxt   = acc + {{IDX_W{i_al_result[ALP_W-1]}}, i_al_result};

`ifdef ALIGN_SCHED_ZERO_SKIP_EN
  logic [IDX_W:0]   fstart;
  logic [EXP_W-1:0] fmax;
  logic [IDX_W-1:0] nxt_idx;
  logic             nxt_found;

  assign fmax       = (state == ALIGN) ? max_q : new_max;
  assign fstart     = (state == ALIGN) ? ({1'b0, idx} + 1'b1) : '0;
  assign first_idx  = nxt_idx;
  assign step_idx   = nxt_idx;
  assign last_align = !nxt_found;
  assign skip_all   = !nxt_found;
`else
  assign first_idx  = '0;
  assign step_idx   = idx + 1'b1;
  assign last_align = (idx == LAST);
  assign skip_all   = 1'b0;
`endif

  align_sched_buf #(.NUM_PP(NUM_PP), .IDX_W(IDX_W)) u_buf (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .we        (accept),
    .waddr     (cnt),
    .wr_pp     (i_denorm_pp),
    .wr_exp    (i_exp),
    .raddr     (idx),
`ifdef ALIGN_SCHED_ZERO_SKIP_EN
    .fmax      (fmax),
    .fstart    (fstart),
    .nxt_idx   (nxt_idx),
    .nxt_found (nxt_found),
`endif
    .rd_pp     (rd_pp),
    .rd_exp    (rd_exp)
  );

  // Aligner inputs follow the buffer only in ALIGN and keep the last replayed entry otherwise
  assign o_al_pp      = (state == ALIGN) ? rd_pp  : hold_pp;
  assign o_al_exp     = (state == ALIGN) ? rd_exp : hold_exp;
  assign o_al_max_exp = (state == ALIGN) ? max_q  : hold_max;
  assign o_busy       = (state != IDLE);

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (accept)     nstate = LOAD;
      LOAD:    if (last_beat)  nstate = skip_all ? DONE : ALIGN;
      ALIGN:   if (last_align) nstate = DONE;
      DONE:    if (i_ready)    nstate = IDLE;
      default:                 nstate = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= nstate;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pp_ready <= 1'b0;
      o_valid    <= 1'b0;
      o_sum      <= '0;
      o_max_exp  <= '0;
      cnt        <= '0;
      idx        <= '0;
      max_q      <= '0;
      acc        <= '0;
      hold_pp    <= '0;
      hold_exp   <= '0;
      hold_max   <= '0;
    end else begin
      o_pp_ready <= (nstate == IDLE) || (nstate == LOAD);
      o_valid    <= (nstate == DONE);
      if (accept) begin
        max_q <= new_max;
        cnt   <= last_beat ? '0 : cnt + 1'b1;
      end
      if (last_beat) begin
        acc <= '0;
        idx <= first_idx;
        if (skip_all) begin
          o_sum     <= '0;
          o_max_exp <= new_max;
        end
      end
      if (state == ALIGN) begin
        acc      <= sum_nxt;
        idx      <= step_idx;
        hold_pp  <= rd_pp;
        hold_exp <= rd_exp;
        hold_max <= max_q;
        if (last_align) begin
          o_sum     <= sum_nxt;
          o_max_exp <= max_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_align_sched.sv
// Randomized and directed scoreboard bench for align_sched with a behavioural aligner and sum model.
// The ALIGN_SCHED_ZERO_SKIP_EN macro selects the skip-build expectations and directed cases.
module tb_align_sched;

  localparam int NUM_PP = 4;
  localparam int ACC_W  = 17;

  logic              i_clk;
  logic              i_rst_n;
  logic              i_pp_valid;
  logic              o_pp_ready;
  logic [3:0]        i_denorm_pp;
  logic [5:0]        i_exp;
  logic [3:0]        o_al_pp;
  logic [5:0]        o_al_exp;
  logic [5:0]        o_al_max_exp;
  logic [14:0]       i_al_result;
  logic              o_valid;
  logic              i_ready;
  logic [ACC_W-1:0]  o_sum;
  logic [5:0]        o_max_exp;
  logic              o_busy;

  typedef struct {
    int sum;
    int mx;
    int k;
    int lat;
    int lpp;
    int lexp;
    bit hold_chk;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_hs = 0;
  int   hs_cyc = 0;
  bit   prev_vld = 0;

  align_sched #(.NUM_PP(NUM_PP)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_pp_valid   (i_pp_valid),
    .o_pp_ready   (o_pp_ready),
    .i_denorm_pp  (i_denorm_pp),
    .i_exp        (i_exp),
    .o_al_pp      (o_al_pp),
    .o_al_exp     (o_al_exp),
    .o_al_max_exp (o_al_max_exp),
    .i_al_result  (i_al_result),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_sum        (o_sum),
    .o_max_exp    (o_max_exp),
    .o_busy       (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Value of 1.ff magnitude scaled by 2^11 and shifted right by the exponent gap
  function automatic int align_val(input logic [3:0] pp, input int diff);
    int m;
    if (diff < 0 || diff >= 12) return 0;
    m = (int'(pp[2:0]) << 11) >> diff;
    return pp[3] ? -m : m;
  endfunction

  function automatic logic [14:0] al_model(input logic [3:0] pp, input logic [5:0] e, input logic [5:0] mx);
    return 15'(align_val(pp, int'(mx) - int'(e)));
  endfunction

  assign i_al_result = al_model(o_al_pp, o_al_exp, o_al_max_exp);

  task automatic check(input string nm, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic send_beat(input logic [3:0] pp, input logic [5:0] e, output int acc_cyc);
    int t;
    t = 0;
    i_pp_valid  = 1'b1;
    i_denorm_pp = pp;
    i_exp       = e;
    @(negedge i_clk);
    while (!o_pp_ready && t < 200) begin
      @(negedge i_clk);
      t++;
    end
    check("beat_ready_timeout", int'(o_pp_ready), 1);
    @(posedge i_clk);
    #1;
    acc_cyc    = cyc;
    i_pp_valid = 1'b0;
  endtask

  task automatic send_op(input logic [NUM_PP-1:0][3:0] pp, input logic [NUM_PP-1:0][5:0] ex,
                         input bit push, input bit gaps);
    exp_t e;
    int   k, mx, ns, d;
    i_ready = 1'b0;
    mx = 0;
    ns = 0;
    for (int i = 0; i < NUM_PP; i++) if (int'(ex[i]) > mx) mx = int'(ex[i]);
    e.sum = 0; e.lpp = 0; e.lexp = 0; e.hold_chk = 0;
    for (int i = 0; i < NUM_PP; i++) begin
      d = mx - int'(ex[i]);
      e.sum += align_val(pp[i], d);
`ifdef ALIGN_SCHED_ZERO_SKIP_EN
      if (pp[i][2:0] != 3'b000 && d < 12) begin
        ns++; e.lpp = int'(pp[i]); e.lexp = int'(ex[i]); e.hold_chk = 1;
      end
`else
      ns++; e.lpp = int'(pp[i]); e.lexp = int'(ex[i]); e.hold_chk = 1;
`endif
    end
`ifdef ALIGN_SCHED_ZERO_SKIP_EN
    e.lat = ns + 1;
`else
    e.lat = NUM_PP + 1;
`endif
    k = 0;
    for (int i = 0; i < NUM_PP; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge i_clk); #1; end
      send_beat(pp[i], ex[i], k);
    end
    e.mx = mx;
    e.k  = k;
    if (push) sb.push_back(e);
  endtask

  task automatic expect_result(input string nm, input int sum, input int mx);
    int t;
    t = 0;
    @(negedge i_clk);
    while (!o_valid && t < 100) begin
      @(negedge i_clk);
      t++;
    end
    check({nm, "_valid"}, int'(o_valid), 1);
    check({nm, "_sum"}, int'($signed(o_sum)), sum);
    check({nm, "_max"}, int'(o_max_exp), mx);
  endtask

  task automatic finish_op();
    int start, t;
    start = n_hs;
    t = 0;
    while (n_hs == start && t < 300) begin
      @(posedge i_clk);
      #1;
      i_ready = ($urandom_range(0, 3) != 0);
      t++;
    end
    check("handshake_timeout", int'(n_hs != start), 1);
    i_ready = 1'b0;
  endtask

  // Monitor: latency, hold behaviour and result comparison against the scoreboard
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      prev_vld = 1'b0;
    end else begin
      if (o_valid && !prev_vld) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", int'(o_valid), 0);
        end else begin
          check("latency", cyc - sb[0].k, sb[0].lat - 1);
          if (sb[0].hold_chk) begin
            check("al_pp_hold", int'(o_al_pp), sb[0].lpp);
            check("al_exp_hold", int'(o_al_exp), sb[0].lexp);
            check("al_max_hold", int'(o_al_max_exp), sb[0].mx);
          end
        end
      end
      if (o_valid && !i_ready && sb.size() != 0) begin
        check("stall_sum", int'($signed(o_sum)), sb[0].sum);
        check("stall_max", int'(o_max_exp), sb[0].mx);
        check("stall_pp_ready", int'(o_pp_ready), 0);
      end
      if (o_valid && i_ready) begin
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("sb_sum", int'($signed(o_sum)), mon_e.sum);
          check("sb_max", int'(o_max_exp), mon_e.mx);
        end
        hs_cyc = cyc + 1;
        n_hs++;
      end
      prev_vld = o_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_PP-1:0][3:0] pp;
    logic [NUM_PP-1:0][5:0] ex;
    exp_t e;
    int   k;

    i_rst_n     = 1'b0;
    i_pp_valid  = 1'b1;
    i_denorm_pp = 4'b0111;
    i_exp       = 6'd9;
    i_ready     = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_pp_ready", int'(o_pp_ready), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_sum", int'(o_sum), 0);
    check("rst_max", int'(o_max_exp), 0);
    check("rst_al_pp", int'(o_al_pp), 0);
    check("rst_al_exp", int'(o_al_exp), 0);
    check("rst_al_max", int'(o_al_max_exp), 0);
    @(posedge i_clk);
    #1;
    i_pp_valid = 1'b0;
    i_rst_n    = 1'b1;
    @(negedge i_clk);
    check("idle_busy", int'(o_busy), 0);

    send_op({4'b0100, 4'b0100, 4'b0100, 4'b0100}, {6'd5, 6'd5, 6'd5, 6'd5}, 1, 0);
    expect_result("equal_exp", 32768, 5);
    finish_op();

    send_op({4'b0100, 4'b0100, 4'b0100, 4'b1100}, {6'd0, 6'd0, 6'd5, 6'd5}, 1, 0);
    expect_result("signed_mix", 512, 5);
    finish_op();

    send_op({4'b0111, 4'b0111, 4'b0111, 4'b0111}, {6'd20, 6'd3, 6'd20, 6'd0}, 1, 0);
    expect_result("big_gap", 28672, 20);
    finish_op();

    // Largest positive sum, then back-pressure with the next beat already offered
    send_op({4'b0111, 4'b0111, 4'b0111, 4'b0111}, {6'd9, 6'd9, 6'd9, 6'd9}, 1, 0);
    expect_result("max_pos", 57344, 9);
    i_pp_valid  = 1'b1;
    i_denorm_pp = 4'b1111;
    i_exp       = 6'd9;
    repeat (10) @(negedge i_clk);
    check("bp_valid_held", int'(o_valid), 1);
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    send_beat(4'b1111, 6'd9, k);
    check("accept_after_hs", k, hs_cyc + 1);
    i_ready = 1'b0;
    for (int i = 1; i < NUM_PP; i++) send_beat(4'b1111, 6'd9, k);
    e.sum = -57344; e.mx = 9; e.k = k; e.lat = NUM_PP + 1;
    e.lpp = 15; e.lexp = 9; e.hold_chk = 1;
    sb.push_back(e);
    expect_result("max_neg", -57344, 9);
    finish_op();

    // Reset in the middle of ALIGN: no result, then a clean operation
    send_op({4'b0100, 4'b0100, 4'b0100, 4'b0100}, {6'd3, 6'd3, 6'd3, 6'd3}, 0, 0);
    repeat (2) begin @(posedge i_clk); #1; end
    check("mid_busy", int'(o_busy), 1);
    i_rst_n = 1'b0;
    #1;
    check("arst_valid", int'(o_valid), 0);
    check("arst_busy", int'(o_busy), 0);
    check("arst_pp_ready", int'(o_pp_ready), 0);
    check("arst_sum", int'(o_sum), 0);
    check("arst_max", int'(o_max_exp), 0);
    check("arst_al_pp", int'(o_al_pp), 0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    send_op({4'b0001, 4'b0110, 4'b1011, 4'b0101}, {6'd6, 6'd2, 6'd6, 6'd4}, 1, 0);
    expect_result("post_reset", -768, 6);
    finish_op();

`ifdef ALIGN_SCHED_ZERO_SKIP_EN
    send_op({4'b0000, 4'b0000, 4'b0100, 4'b0000}, {6'd7, 6'd7, 6'd7, 6'd7}, 1, 0);
    expect_result("skip_one", 8192, 7);
    finish_op();
    send_op({4'b1000, 4'b0000, 4'b1000, 4'b0000}, {6'd2, 6'd4, 6'd1, 6'd3}, 1, 0);
    expect_result("skip_all", 0, 4);
    finish_op();
`endif

    repeat (25) begin
      pp = 16'($urandom);
      for (int i = 0; i < NUM_PP; i++) ex[i] = 6'($urandom_range(0, 20));
      send_op(pp, ex, 1, 1);
      finish_op();
    end

    repeat (5) @(negedge i_clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
